// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory port between the multi-cycle core (requester 0) and the
// program loader / debug port (requester 1). Only one transaction is in
// flight at a time. The winner is registered, the memory is driven for one
// cycle, the arbiter waits out the read latency, and then it acks the owner.
//
// Parameters
//   ADDR_W      address width
//   DATA_W      data width (DATA_W/8 byte lanes)
//   MEM_LATENCY cycles from mem_en to valid mem_rdata (>= 1)
//   FIXED_PRIO  1: requester 0 always wins a tie, 0: round-robin
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req, we               per-requester request / write enable
//   addr, wdata, wmask    per-requester fields, requester i in slice i
//   gnt                   one-hot pulse, request accepted this cycle
//   ack                   one-hot pulse, transaction complete
//   rdata                 last read data captured from memory
//   busy                  high whenever the arbiter is not idle
//   mem_en, mem_we        memory strobe / write enable (ISSUE cycle only)
//   mem_addr, mem_wdata,
//   mem_wmask             latched transaction fields
//   mem_rdata             memory read data, valid MEM_LATENCY after mem_en
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int FIXED_PRIO  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [2*ADDR_W-1:0]     addr,
  input  logic [2*DATA_W-1:0]     wdata,
  input  logic [2*(DATA_W/8)-1:0] wmask,
  output logic [1:0]              gnt,
  output logic [1:0]              ack,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic [DATA_W/8-1:0]     mem_wmask,
  input  logic [DATA_W-1:0]       mem_rdata
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t              state_reg, state_next;
  logic                owner_reg;
  logic                last_reg;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [MASK_W-1:0]   wmask_reg;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [DATA_W-1:0]   rdata_reg;

  logic                winner;
  logic                latch_en;
  logic                capture_en;

  // Per-requester views of the packed request buses.
  logic [ADDR_W-1:0]   addr_req  [2];
  logic [DATA_W-1:0]   wdata_req [2];
  logic [MASK_W-1:0]   wmask_req [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign addr_req[gi]  = addr[gi*ADDR_W +: ADDR_W];
    assign wdata_req[gi] = wdata[gi*DATA_W +: DATA_W];
    assign wmask_req[gi] = wmask[gi*MASK_W +: MASK_W];
  end

  // A lone requester always wins; on a tie round-robin favours whoever was
  // not served last, fixed priority favours the core.
  always_comb begin
    winner = req[1];
    if (req == 2'b11) begin
      winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gnt        = 2'b00;
    ack        = 2'b00;
    latch_en   = 1'b0;
    capture_en = 1'b0;
    case (state_reg)
      IDLE: begin
        // Reset wins over a simultaneous request so gnt never pulses in reset.
        if ((|req) && !reset) begin
          gnt[winner] = 1'b1;
          latch_en    = 1'b1;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        if (we_reg) begin
          state_next = ACK;
        end else begin
          cnt_next   = CNT_W'(MEM_LATENCY);
          state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          capture_en = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        ack[owner_reg] = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wmask_reg <= '0;
      cnt_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (latch_en) begin
        owner_reg <= winner;
        last_reg  <= winner;
        we_reg    <= we[winner];
        addr_reg  <= addr_req[winner];
        wdata_reg <= wdata_req[winner];
        wmask_reg <= wmask_req[winner];
      end
      if (capture_en) begin
        rdata_reg <= mem_rdata;
      end
    end
  end

  assign busy      = (state_reg != IDLE);
  assign mem_en    = (state_reg == ISSUE);
  assign mem_we    = (state_reg == ISSUE) && we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_wmask = wmask_reg;
  assign rdata     = rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Three arbiter instances with private stimulus:
//   0: MEM_LATENCY=1, round-robin
//   1: MEM_LATENCY=3, round-robin
//   2: MEM_LATENCY=1, fixed priority
// Each has a small memory model that presents read data exactly LAT cycles
// after a read strobe and a poison pattern at all other times.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_v     [3];
  logic [1:0]  req_v       [3];
  logic [1:0]  we_v        [3];
  logic [63:0] addr_v      [3];
  logic [63:0] wdata_v     [3];
  logic [7:0]  wmask_v     [3];
  logic [1:0]  gnt_v       [3];
  logic [1:0]  ack_v       [3];
  logic [31:0] rdata_v     [3];
  logic        busy_v      [3];
  logic        mem_en_v    [3];
  logic        mem_we_v    [3];
  logic [31:0] mem_addr_v  [3];
  logic [31:0] mem_wdata_v [3];
  logic [3:0]  mem_wmask_v [3];
  logic [31:0] mem_rdata_v [3];

  int n_total = 0;
  int n_bad   = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT = (gi == 1) ? 3 : 1;
    localparam int FP  = (gi == 2) ? 1 : 0;
    logic [31:0] pipe [3];

    mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .FIXED_PRIO(FP)
    ) u_dut (
      .clk       (clk),
      .reset     (reset_v[gi]),
      .req       (req_v[gi]),
      .we        (we_v[gi]),
      .addr      (addr_v[gi]),
      .wdata     (wdata_v[gi]),
      .wmask     (wmask_v[gi]),
      .gnt       (gnt_v[gi]),
      .ack       (ack_v[gi]),
      .rdata     (rdata_v[gi]),
      .busy      (busy_v[gi]),
      .mem_en    (mem_en_v[gi]),
      .mem_we    (mem_we_v[gi]),
      .mem_addr  (mem_addr_v[gi]),
      .mem_wdata (mem_wdata_v[gi]),
      .mem_wmask (mem_wmask_v[gi]),
      .mem_rdata (mem_rdata_v[gi])
    );

    always @(posedge clk) begin
      pipe[0] <= (mem_en_v[gi] && !mem_we_v[gi]) ? mem_fn(mem_addr_v[gi]) : 32'hBAD0_BAD0;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign mem_rdata_v[gi] = pipe[LAT-1];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  int ng;
  int na;
  int gcyc [4];

  initial begin
    for (int k = 0; k < 3; k++) begin
      reset_v[k] = 1'b1; req_v[k] = 2'b00; we_v[k] = 2'b00;
      addr_v[k] = '0; wdata_v[k] = '0; wmask_v[k] = '0;
    end
    req_v[0] = 2'b11;   // request during reset must not be granted
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt",    gnt_v[0],      2'b00);
    check("rst_ack",    ack_v[0],      2'b00);
    check("rst_busy",   busy_v[0],     1'b0);
    check("rst_mem_en", mem_en_v[0],   1'b0);
    check("rst_mem_we", mem_we_v[0],   1'b0);
    check("rst_rdata",  rdata_v[0],    32'h0);
    check("rst_maddr",  mem_addr_v[0], 32'h0);
    check("rst_mmask",  mem_wmask_v[0], 4'h0);
    @(posedge clk); #1;
    req_v[0] = 2'b00;
    for (int k = 0; k < 3; k++) reset_v[k] = 1'b0;

    // ---- single read, latency 1 ----
    @(posedge clk); #1;
    req_v[0] = 2'b01; we_v[0] = 2'b00; addr_v[0] = {32'h0, 32'h100};
    @(negedge clk);
    check("rd_gnt_c0",  gnt_v[0], 2'b01);
    check("rd_busy_c0", busy_v[0], 1'b0);
    @(posedge clk); #1; req_v[0] = 2'b00;
    @(negedge clk);
    check("rd_en_c1",   mem_en_v[0], 1'b1);
    check("rd_we_c1",   mem_we_v[0], 1'b0);
    check("rd_addr_c1", mem_addr_v[0], 32'h100);
    check("rd_busy_c1", busy_v[0], 1'b1);
    @(posedge clk); @(negedge clk);
    check("rd_ack_c2",  ack_v[0], 2'b00);
    check("rd_en_c2",   mem_en_v[0], 1'b0);
    @(posedge clk); @(negedge clk);
    check("rd_ack_c3",  ack_v[0], 2'b01);
    check("rd_data_c3", rdata_v[0], 32'hDEAD_BEEF);
    @(posedge clk); @(negedge clk);
    check("rd_busy_c4", busy_v[0], 1'b0);
    check("rd_ack_c4",  ack_v[0], 2'b00);

    // ---- masked write from loader ----
    @(posedge clk); #1;
    req_v[0] = 2'b10; we_v[0] = 2'b10; addr_v[0] = {32'h40, 32'h0};
    wdata_v[0] = {32'h1234_5678, 32'h0}; wmask_v[0] = 8'h30;
    @(negedge clk);
    check("wr_gnt_c0", gnt_v[0], 2'b10);
    @(posedge clk); #1; req_v[0] = 2'b00; we_v[0] = 2'b00;
    @(negedge clk);
    check("wr_en_c1",    mem_en_v[0], 1'b1);
    check("wr_we_c1",    mem_we_v[0], 1'b1);
    check("wr_addr_c1",  mem_addr_v[0], 32'h40);
    check("wr_wdata_c1", mem_wdata_v[0], 32'h1234_5678);
    check("wr_wmask_c1", mem_wmask_v[0], 4'h3);
    check("wr_ack_c1",   ack_v[0], 2'b00);
    @(posedge clk); @(negedge clk);
    check("wr_we_c2",    mem_we_v[0], 1'b0);
    check("wr_ack_c2",   ack_v[0], 2'b10);
    check("wr_rdata_c2", rdata_v[0], 32'hDEAD_BEEF);
    @(posedge clk); @(negedge clk);
    check("wr_busy_c3",  busy_v[0], 1'b0);

    // ---- round-robin tie out of reset ----
    @(posedge clk); #1; reset_v[0] = 1'b1;
    @(posedge clk); #1; reset_v[0] = 1'b0;
    ng = 0; na = 0;
    req_v[0] = 2'b11; we_v[0] = 2'b00; addr_v[0] = {32'h200, 32'h100};
    for (int cyc = 0; cyc < 40 && na < 4; cyc++) begin
      @(negedge clk);
      if (gnt_v[0] != 2'b00 && ack_v[0] != 2'b00)
        check($sformatf("rr_gnt_ack_overlap_c%0d", cyc), {gnt_v[0], ack_v[0]}, {gnt_v[0], 2'b00});
      if (gnt_v[0] != 2'b00) begin
        if (ng < 4) begin
          check($sformatf("rr_gnt%0d", ng), gnt_v[0], (ng % 2 == 0) ? 2'b01 : 2'b10);
          gcyc[ng] = cyc;
        end
        ng++;
      end
      if (ack_v[0] != 2'b00) begin
        if (na < 4 && na < ng) begin
          check($sformatf("rr_ack%0d", na), ack_v[0], (na % 2 == 0) ? 2'b01 : 2'b10);
          check($sformatf("rr_ack%0d_lat", na), 64'(cyc - gcyc[na]), 64'd3);
        end
        na++;
      end
      @(posedge clk); #1;
      if (ng >= 4) req_v[0] = 2'b00;
    end
    req_v[0] = 2'b00;
    check("rr_ngnt", 64'(ng), 64'd4);
    check("rr_nack", 64'(na), 64'd4);

    // ---- fixed priority ----
    ng = 0;
    req_v[2] = 2'b11; we_v[2] = 2'b00; addr_v[2] = {32'h300, 32'h20};
    for (int cyc = 0; cyc < 60 && ng < 5; cyc++) begin
      @(negedge clk);
      if (gnt_v[2] != 2'b00) begin
        check($sformatf("fp_gnt%0d", ng), gnt_v[2], (ng < 4) ? 2'b01 : 2'b10);
        ng++;
      end
      @(posedge clk); #1;
      if (ng == 4) req_v[2] = 2'b10;
      if (ng >= 5) req_v[2] = 2'b00;
    end
    req_v[2] = 2'b00;
    check("fp_ngnt", 64'(ng), 64'd5);

    // ---- read with latency 3 ----
    @(posedge clk); #1;
    req_v[1] = 2'b01; we_v[1] = 2'b00; addr_v[1] = {32'h0, 32'h8};
    @(negedge clk);
    check("l3_gnt_c0",  gnt_v[1], 2'b01);
    check("l3_busy_c0", busy_v[1], 1'b0);
    @(posedge clk); #1; req_v[1] = 2'b00;
    @(negedge clk);
    check("l3_en_c1",   mem_en_v[1], 1'b1);
    check("l3_addr_c1", mem_addr_v[1], 32'h8);
    check("l3_busy_c1", busy_v[1], 1'b1);
    for (int c = 2; c <= 4; c++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("l3_busy_c%0d", c),  busy_v[1], 1'b1);
      check($sformatf("l3_ack_c%0d", c),   ack_v[1], 2'b00);
      check($sformatf("l3_en_c%0d", c),    mem_en_v[1], 1'b0);
      check($sformatf("l3_rdata_c%0d", c), rdata_v[1], 32'h0);
    end
    @(posedge clk); @(negedge clk);
    check("l3_ack_c5",   ack_v[1], 2'b01);
    check("l3_busy_c5",  busy_v[1], 1'b1);
    check("l3_rdata_c5", rdata_v[1], 32'h0008_FFF7);
    @(posedge clk); @(negedge clk);
    check("l3_busy_c6",  busy_v[1], 1'b0);

    // ---- reset mid-WAIT ----
    @(posedge clk); #1;
    req_v[1] = 2'b01; addr_v[1] = {32'h0, 32'h10};
    @(negedge clk);
    check("mr_gnt_c0", gnt_v[1], 2'b01);
    @(posedge clk); #1; req_v[1] = 2'b00;
    @(negedge clk);
    check("mr_en_c1", mem_en_v[1], 1'b1);
    @(posedge clk); #1; reset_v[1] = 1'b1;
    @(negedge clk);
    check("mr_busy_c2", busy_v[1], 1'b1);
    @(posedge clk); #1; reset_v[1] = 1'b0;
    @(negedge clk);
    check("mr_busy_c3",  busy_v[1], 1'b0);
    check("mr_ack_c3",   ack_v[1], 2'b00);
    check("mr_rdata_c3", rdata_v[1], 32'h0);
    check("mr_en_c3",    mem_en_v[1], 1'b0);
    check("mr_addr_c3",  mem_addr_v[1], 32'h0);
    for (int c = 4; c <= 6; c++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("mr_noack_c%0d", c), {busy_v[1], ack_v[1]}, 3'b000);
    end
    @(posedge clk); #1;
    req_v[1] = 2'b11; addr_v[1] = {32'h44, 32'h4};
    @(negedge clk);
    check("mr_tie_gnt", gnt_v[1], 2'b01);
    @(posedge clk); #1; req_v[1] = 2'b00;
    repeat (6) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
